mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port between the multi-cycle
//  MIPS core (fetch/load/store states) and a debug/loader port. Runs one transaction
//  at a time through an IDLE/ISSUE/WAIT/DONE sequencer with round-robin priority.
//  Produces cpu_stall so the core's state register holds while its access is pending.
// PARAMETERS
//  ADDR_W   32  address width, all ports
//  DATA_W   32  data width, all ports
//  MEM_LAT  2   cycles from the ISSUE cycle to mem_rdata valid; legal 1..15
// PORTS
//  cclk       in   1       clock, rising edge
//  rstb       in   1       reset, asynchronous, active-low
//  cpu_req    in   1       core access request (MemRead|MemWrite); held until cpu_done
//  cpu_we     in   1       1 = write, 0 = read; valid with cpu_req
//  cpu_addr   in   ADDR_W  core address
//  cpu_wdata  in   DATA_W  core write data
//  cpu_rdata  out  DATA_W  core read data, registered
//  cpu_done   out  1       one-cycle completion pulse to core
//  cpu_stall  out  1       cpu_req & ~cpu_done; core holds state while high
//  dbg_req    in   1       debug access request; held until dbg_done
//  dbg_we     in   1       1 = write, 0 = read
//  dbg_addr   in   ADDR_W  debug address
//  dbg_wdata  in   DATA_W  debug write data
//  dbg_rdata  out  DATA_W  debug read data, registered
//  dbg_done   out  1       one-cycle completion pulse to debug port
//  mem_en     out  1       memory strobe, high only in ISSUE
//  mem_we     out  1       memory write enable, high only in ISSUE with latched we=1
//  mem_addr   out  ADDR_W  latched transaction address
//  mem_wdata  out  DATA_W  latched transaction write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after ISSUE
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (rstb=0, async): state=IDLE, last_grant=DBG, cnt=0; all outputs and latches 0.
//  States:
//  - IDLE: if any request is pending, grant a winner, latch owner/we/addr/wdata,
//    go to ISSUE; otherwise stay in IDLE.
//  - ISSUE: mem_en=1, mem_we=latched we; cnt<=MEM_LAT-1; go to WAIT.
//  - WAIT: if cnt==0, capture mem_rdata into owner's rdata reg (reads only) and go
//    to DONE; else cnt<=cnt-1.
//  - DONE: owner's done=1 (registered decode of state); go to IDLE.
//  Timing: request seen in cycle 0 -> ISSUE in cycle 1 -> MEM_LAT WAIT cycles -> done
//    in cycle MEM_LAT+2. mem_rdata is sampled at the end of cycle 1+MEM_LAT.
//  Arbitration: if only one requester is pending, it wins. If both are pending, the one
//    not in last_grant wins. last_grant updates at grant. After reset the CPU wins first.
//  Handshake: the requester drops req in the cycle after done, because IDLE follows DONE.
//    A req still high in that IDLE cycle is taken as a new request.
//  Latched addr/wdata/we are frozen from grant to DONE. Input changes mid-transaction
//    are ignored. mem_addr/mem_wdata hold their last value in IDLE.
//  Req dropped mid-transaction: the transaction still completes and done still pulses.
//  rdata: on a read completion, updates only the owner's register. It holds until that
//    owner's next read. Writes leave rdata unchanged.
//  Reset mid-transaction: mem_en/mem_we/done drop immediately and no done is issued.
//    Arbitration restarts from reset priority.
//  Only one done per cycle. cpu_done and dbg_done are never high together.
// TESTING
//  1 rstb=0 during WAIT -> mem_en=0, cpu_done=0, busy=0 at once. After release,
//    cpu read 0x40 is serviced normally.
//  2 MEM_LAT=2, cpu read 0x40, mem_rdata=0xDEADBEEF -> mem_en cycle 1,
//    cpu_done cycle 4, cpu_rdata=0xDEADBEEF, cpu_stall=1 cycles 0-3.
//  3 cpu_req and dbg_req both high after reset, repeated 4 times -> grants
//    CPU, DBG, CPU, DBG; no cycle has both done outputs high.
//  4 dbg write 0x100 <= 0x12345678 -> mem_we=1 only in ISSUE, mem_wdata=0x12345678,
//    dbg_done cycle 4, cpu_done=0, cpu_rdata unchanged.
//  5 cpu_addr changed from 0x40 to 0x80 during WAIT -> mem_addr stays 0x40
//    until next grant.
//  6 MEM_LAT=1 and MEM_LAT=15 reads -> cpu_done at cycle 3 and cycle 17.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the unified memory-port arbiter: core port, debug/loader port,
// memory port and status. The arbiter connects through the slave modport; the
// requesters and the memory model connect through the master modport.
//
// Handshake (both requester ports): a requester raises req with we/addr/wdata
// valid and holds req until it sees its one-cycle done pulse. It must drop req
// in the cycle after done, because a req still high in the IDLE cycle that
// follows done is accepted as a new request.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // core port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;
    // debug/loader port
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_done;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status: busy plus the raw sequencer state for observation
    logic              busy;
    logic [1:0]        fsm_state;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, fsm_state
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, fsm_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified instruction/data memory port arbiter. Shares one memory port between
// the multi-cycle core and the debug/loader port, one transaction at a time,
// through an IDLE -> ISSUE -> WAIT -> DONE sequencer. When both ports request
// in the same IDLE cycle, the port that did not win last time is granted.
// All memory-side strobes and done pulses are registered.
//
// Timing for a request first seen in cycle 0:
//   cycle 1              ISSUE  (mem_en high)
//   cycles 2..1+MEM_LAT  WAIT   (mem_rdata sampled at the end of cycle 1+MEM_LAT)
//   cycle MEM_LAT+2      DONE   (owner's done high, read data already visible)
// MEM_LAT must lie in 1..15 so that MEM_LAT-1 fits the 4-bit wait counter.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic cclk,
    input logic rstb,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // owner / last_grant encoding
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_en;
    logic               r_mem_we;
    logic               r_cpu_done;
    logic               r_dbg_done;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_dbg_rdata;

    logic               w_any_req;
    logic               w_grant_dbg;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    // Round-robin pick: a lone requester wins; on a tie the debug port wins
    // only if the core was granted last. Reset leaves last_grant at DBG so
    // the core wins the first tie.
    assign w_any_req   = bus.cpu_req | bus.dbg_req;
    assign w_grant_dbg = bus.dbg_req & (~bus.cpu_req | (r_last_grant == OWN_CPU));
    assign w_sel_we    = w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    // Sequencer with registered strobes; single-cycle outputs default low.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= S_IDLE;
            r_last_grant <= OWN_DBG;
            r_owner      <= OWN_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_dbg_done   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_done <= 1'b0;
            r_dbg_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // latch the winner; these stay frozen until the next grant
                        r_owner      <= w_grant_dbg;
                        r_last_grant <= w_grant_dbg;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= w_sel_we;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // reads land only in the owner's register; writes leave both alone
                        if (!r_we) begin
                            if (r_owner == OWN_DBG) begin
                                r_dbg_rdata <= bus.mem_rdata;
                            end else begin
                                r_cpu_rdata <= bus.mem_rdata;
                            end
                        end
                        r_cpu_done <= (r_owner == OWN_CPU);
                        r_dbg_done <= (r_owner == OWN_DBG);
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.dbg_done  = r_dbg_done;
    // the core freezes its state register while its access is outstanding
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_done;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one MEM_LAT=2 instance for the main tests plus
// MEM_LAT=1 and MEM_LAT=15 instances for the latency extremes. A word memory
// model returns read data only in the single cycle MEM_LAT after ISSUE and
// drives a filler value otherwise.
module tb_mem_port_arbiter;

  localparam int BUDGET = 40;

  // ---------------- clock / reset ----------------
  logic cclk;
  logic rstb;

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  mem_port_arbiter_if bi ();
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();

  mem_port_arbiter #(.MEM_LAT(2))  u_dut  (.cclk(cclk), .rstb(rstb), .bus(bi.slave));
  mem_port_arbiter #(.MEM_LAT(1))  u_lat1 (.cclk(cclk), .rstb(rstb), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(15)) u_lat15(.cclk(cclk), .rstb(rstb), .bus(b2.slave));

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  logic        pv [3][16];
  logic [31:0] pd [3][16];
  logic        l_en [3];
  logic        l_we [3];
  logic [31:0] l_addr [3];

  assign l_en[0] = bi.mem_en;  assign l_we[0] = bi.mem_we;  assign l_addr[0] = bi.mem_addr;
  assign l_en[1] = b1.mem_en;  assign l_we[1] = b1.mem_we;  assign l_addr[1] = b1.mem_addr;
  assign l_en[2] = b2.mem_en;  assign l_we[2] = b2.mem_we;  assign l_addr[2] = b2.mem_addr;

  always @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 32'hDEAD_BEEF;   // 0x40
      mem[32] <= 32'h8080_8080;   // 0x80
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 16; i++) begin
          pv[k][i] <= 1'b0;
          pd[k][i] <= '0;
        end
      end
    end else begin
      if (l_en[0] && l_we[0]) mem[l_addr[0][9:2]] <= bi.mem_wdata;
      for (int k = 0; k < 3; k++) begin
        for (int i = 15; i > 0; i--) begin
          pv[k][i] <= pv[k][i-1];
          pd[k][i] <= pd[k][i-1];
        end
        pv[k][0] <= l_en[k] && !l_we[k];
        pd[k][0] <= mem[l_addr[k][9:2]];
      end
    end
  end

  // stage L-1 is visible in cycle 1+L after ISSUE
  assign bi.mem_rdata = pv[0][1]  ? pd[0][1]  : 32'hBAD0_BAD0;
  assign b1.mem_rdata = pv[1][0]  ? pd[1][0]  : 32'hBAD0_BAD0;
  assign b2.mem_rdata = pv[2][14] ? pd[2][14] : 32'hBAD0_BAD0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int both_cnt = 0;

  always @(negedge cclk) begin
    if (bi.cpu_done && bi.dbg_done) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  int          t_done_cyc, t_en_cnt, t_en_cyc, t_stall_cnt, t_wrong_done;
  int          t_addr_bad, t_we_bad;
  logic        t_we_seen, t_stall_at_done, t_idle_busy;
  logic [31:0] t_wdata_seen, t_post_addr;

  // mode 0: plain, 1: change cpu_addr/wdata in WAIT, 2: drop req in WAIT
  task automatic do_txn(input logic is_dbg, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int mode);
    int  cyc;
    bit  done;
    logic own_done, other_done;
    @(posedge cclk); #1;
    if (is_dbg) begin
      bi.dbg_we = we; bi.dbg_addr = addr; bi.dbg_wdata = wdata; bi.dbg_req = 1'b1;
    end else begin
      bi.cpu_we = we; bi.cpu_addr = addr; bi.cpu_wdata = wdata; bi.cpu_req = 1'b1;
    end
    t_done_cyc = -1; t_en_cnt = 0; t_en_cyc = -1; t_stall_cnt = 0; t_wrong_done = 0;
    t_addr_bad = 0; t_we_bad = 0; t_we_seen = 1'b0; t_stall_at_done = 1'b1; t_wdata_seen = '0;
    done = 0;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge cclk);
      if (bi.mem_en) begin
        t_en_cnt++; t_en_cyc = cyc; t_we_seen = bi.mem_we; t_wdata_seen = bi.mem_wdata;
      end
      if (bi.mem_we && !bi.mem_en) t_we_bad++;
      if (cyc >= 1 && bi.mem_addr !== addr) t_addr_bad++;
      if (bi.cpu_stall) t_stall_cnt++;
      own_done   = is_dbg ? bi.dbg_done : bi.cpu_done;
      other_done = is_dbg ? bi.cpu_done : bi.dbg_done;
      if (other_done) t_wrong_done++;
      if (own_done) begin
        t_done_cyc = cyc; t_stall_at_done = bi.cpu_stall; done = 1;
        bi.cpu_req = 1'b0; bi.dbg_req = 1'b0;
      end
      if (mode == 1 && cyc == 2) begin bi.cpu_addr = 32'h80; bi.cpu_wdata = 32'h5555_AAAA; end
      if (mode == 2 && cyc == 2) begin bi.cpu_req = 1'b0; bi.dbg_req = 1'b0; end
      cyc++;
    end
    bi.cpu_req = 1'b0; bi.dbg_req = 1'b0;
    @(negedge cclk);
    t_idle_busy = bi.busy;
    t_post_addr = bi.mem_addr;
  endtask

  task automatic pulse_reset();
    @(negedge cclk); rstb = 1'b0;
    repeat (2) @(negedge cclk);
    rstb = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        is_dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_cpu;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int who [4];
    int d1, d2, c;
    logic w1, w2;

    vecs[0] = '{1'b0, 1'b0, 32'h040, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'h044, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h044, 32'h0,         32'hCAFE_F00D, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h040, 32'h0,         32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h100, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};

    bi.cpu_req = 0; bi.cpu_we = 0; bi.cpu_addr = 0; bi.cpu_wdata = 0;
    bi.dbg_req = 0; bi.dbg_we = 0; bi.dbg_addr = 0; bi.dbg_wdata = 0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = 0; b1.dbg_wdata = 0;
    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = 0; b2.cpu_wdata = 0;
    b2.dbg_req = 0; b2.dbg_we = 0; b2.dbg_addr = 0; b2.dbg_wdata = 0;

    // reset state
    rstb = 1'b0;
    repeat (3) @(negedge cclk);
    check("rst_busy",      32'(bi.busy),      0);
    check("rst_state",     32'(bi.fsm_state), 0);
    check("rst_mem_en",    32'(bi.mem_en),    0);
    check("rst_mem_we",    32'(bi.mem_we),    0);
    check("rst_mem_addr",  bi.mem_addr,       0);
    check("rst_mem_wdata", bi.mem_wdata,      0);
    check("rst_cpu_rdata", bi.cpu_rdata,      0);
    check("rst_dbg_rdata", bi.dbg_rdata,      0);
    check("rst_dones",     32'({bi.cpu_done, bi.dbg_done}), 0);
    rstb = 1'b1;

    // reset during WAIT, then a normal read
    @(posedge cclk); #1;
    bi.cpu_we = 0; bi.cpu_addr = 32'h40; bi.cpu_req = 1'b1;
    repeat (3) @(negedge cclk);
    check("wait_busy",  32'(bi.busy),      1);
    check("wait_state", 32'(bi.fsm_state), 2);
    rstb = 1'b0;
    #1;
    check("rstmid_mem_en",   32'(bi.mem_en),   0);
    check("rstmid_cpu_done", 32'(bi.cpu_done), 0);
    check("rstmid_busy",     32'(bi.busy),     0);
    bi.cpu_req = 1'b0;
    @(negedge cclk);
    rstb = 1'b1;
    do_txn(1'b0, 1'b0, 32'h40, 32'h0, 0);
    check("postrst_done_cyc", 32'(t_done_cyc), 4);
    check("postrst_rdata",    bi.cpu_rdata,    32'hDEAD_BEEF);

    // round-robin after reset with both ports always pending
    pulse_reset();
    @(posedge cclk); #1;
    bi.cpu_we = 0; bi.cpu_addr = 32'h40; bi.dbg_we = 0; bi.dbg_addr = 32'h100;
    bi.cpu_req = 1'b1; bi.dbg_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      who[g] = -1;
      c = 0;
      while (who[g] < 0 && c < BUDGET) begin
        @(negedge cclk);
        if (bi.cpu_done) who[g] = 0;
        else if (bi.dbg_done) who[g] = 1;
        c++;
      end
      bi.cpu_req = 1'b0; bi.dbg_req = 1'b0;
      if (g < 3) begin
        @(posedge cclk); #1;
        bi.cpu_req = 1'b1; bi.dbg_req = 1'b1;
      end
    end
    check("rr_grant0", 32'(who[0]), 0);
    check("rr_grant1", 32'(who[1]), 1);
    check("rr_grant2", 32'(who[2]), 0);
    check("rr_grant3", 32'(who[3]), 1);
    repeat (2) @(negedge cclk);
    check("rr_idle_after", 32'(bi.busy), 0);
    check("rr_both_done",  32'(both_cnt), 0);

    // table-driven single transactions
    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].is_dbg, vecs[v].we, vecs[v].addr, vecs[v].wdata, 0);
      check($sformatf("v%0d_done_cyc", v),   32'(t_done_cyc),   4);
      check($sformatf("v%0d_en_cnt", v),     32'(t_en_cnt),     1);
      check($sformatf("v%0d_en_cyc", v),     32'(t_en_cyc),     1);
      check($sformatf("v%0d_mem_we", v),     32'(t_we_seen),    32'(vecs[v].we));
      check($sformatf("v%0d_we_outside", v), 32'(t_we_bad),     0);
      check($sformatf("v%0d_addr_hold", v),  32'(t_addr_bad),   0);
      if (vecs[v].we) check($sformatf("v%0d_mem_wdata", v), t_wdata_seen, vecs[v].wdata);
      check($sformatf("v%0d_cpu_rdata", v),  bi.cpu_rdata,      vecs[v].exp_cpu);
      check($sformatf("v%0d_dbg_rdata", v),  bi.dbg_rdata,      vecs[v].exp_dbg);
      check($sformatf("v%0d_wrong_done", v), 32'(t_wrong_done), 0);
      check($sformatf("v%0d_stall_cnt", v),  32'(t_stall_cnt),  vecs[v].is_dbg ? 32'd0 : 32'd4);
      check($sformatf("v%0d_stall_done", v), 32'(t_stall_at_done), 0);
      check($sformatf("v%0d_idle_after", v), 32'(t_idle_busy),  0);
    end

    // cpu_addr changes during WAIT: latched address is kept
    do_txn(1'b0, 1'b0, 32'h40, 32'h0, 1);
    check("mut_done_cyc",  32'(t_done_cyc), 4);
    check("mut_addr_hold", 32'(t_addr_bad), 0);
    check("mut_idle_addr", t_post_addr,     32'h40);
    check("mut_rdata",     bi.cpu_rdata,    32'hDEAD_BEEF);

    // req dropped mid-transaction still completes
    do_txn(1'b0, 1'b0, 32'h44, 32'h0, 2);
    check("drop_done_cyc", 32'(t_done_cyc), 4);
    check("drop_rdata",    bi.cpu_rdata,    32'hCAFE_F00D);
    check("drop_idle",     32'(t_idle_busy), 0);

    // latency extremes
    @(posedge cclk); #1;
    b1.cpu_we = 0; b1.cpu_addr = 32'h40; b1.cpu_req = 1'b1;
    b2.cpu_we = 0; b2.cpu_addr = 32'h40; b2.cpu_req = 1'b1;
    d1 = -1; d2 = -1; w1 = 0; w2 = 0;
    for (int cy = 0; cy < BUDGET && (d1 < 0 || d2 < 0); cy++) begin
      @(negedge cclk);
      if (b1.cpu_done && d1 < 0) begin d1 = cy; b1.cpu_req = 1'b0; end
      if (b2.cpu_done && d2 < 0) begin d2 = cy; b2.cpu_req = 1'b0; end
      if (b1.mem_en && cy != 1) w1 = 1;
      if (b2.mem_en && cy != 1) w2 = 1;
    end
    b1.cpu_req = 1'b0; b2.cpu_req = 1'b0;
    check("lat1_done_cyc",  32'(d1), 3);
    check("lat15_done_cyc", 32'(d2), 17);
    check("lat1_rdata",     b1.cpu_rdata, 32'hDEAD_BEEF);
    check("lat15_rdata",    b2.cpu_rdata, 32'hDEAD_BEEF);
    check("lat1_en_cyc",    32'(w1), 0);
    check("lat15_en_cyc",   32'(w2), 0);

    repeat (2) @(negedge cclk);
    check("final_both_done", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
